shift_add_multiplier_16: RTL and testbench

Multi-cycle unsigned 16×16→32 multiplier for the KGP_RISC ALU datapath. It consumes `CLA_16_Bit` as its only adder. One instance of that adder is reused on every iteration of a radix-2 shift-and-add loop, so the wide multiply path adds no second carry chain. The block sits beside the single-cycle ALU ops and uses a Start/Done handshake so the control unit can stall while it runs.

---
 rtl/shift_add_multiplier_16.sv | 142 ++++++++++++++
 tb/tb_shift_add_multiplier_16.sv | 123 ++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_16.sv
// Unsigned 16x16->32 radix-2 shift-and-add multiplier, Start/Done handshake.
// One 16-bit carry-lookahead adder is reused on each of the 16 iterations.

module cla_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c;
  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module CLA_16_Bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out,
  output logic        Block_P,
  output logic        Block_G
);
  localparam int NUM_GRP = 4;

  logic [NUM_GRP-1:0] gp, gg, gc;

  // second-level lookahead over the four 4-bit groups
  assign gc[0] = C_in;
  assign gc[1] = gg[0] | (gp[0] & C_in);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & C_in);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
                 (gp[2] & gp[1] & gp[0] & C_in);

  for (genvar i = 0; i < NUM_GRP; i++) begin : g_grp
    cla_4 u_grp (
      .a  (A[4*i +: 4]),
      .b  (B[4*i +: 4]),
      .cin(gc[i]),
      .s  (S[4*i +: 4]),
      .pg (gp[i]),
      .gg (gg[i])
    );
  end

  assign Block_P = &gp;
  assign Block_G = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
                   (gp[3] & gp[2] & gp[1] & gg[0]);
  assign C_out   = Block_G | (Block_P & C_in);
endmodule

module shift_add_multiplier_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Product
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] mcand, hi, lo;
  logic [3:0]  cnt;
  logic [15:0] sum;
  logic        c_out;
  logic        cla_p_unused, cla_g_unused;
  logic [31:0] shifted;

  CLA_16_Bit u_cla (
    .A      (hi),
    .B      (lo[0] ? mcand : 16'h0000),
    .C_in   (1'b0),
    .S      (sum),
    .C_out  (c_out),
    .Block_P(cla_p_unused),
    .Block_G(cla_g_unused)
  );

  // carry-out lands in hi[15], so the 33-bit partial sum never overflows
  assign shifted = {c_out, sum, lo[15:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_RUN;
      S_RUN:   if (cnt == 4'd15) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != S_IDLE);
    Done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      Product <= '0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          mcand <= A;
          lo    <= B;
          hi    <= '0;
          cnt   <= '0;
        end
        S_RUN: begin
          {hi, lo} <= shifted;
          cnt      <= cnt + 4'd1;
          if (cnt == 4'd15) Product <= shifted;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier_16.sv
// Directed and random checks of shift_add_multiplier_16 against A*B computed
// with plain arithmetic; covers latency, Busy width, Product hold and reset abort.

module tb_shift_add_multiplier_16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Busy, Done;
  logic [31:0] Product;
  int          checks = 0;
  int          errors = 0;

  shift_add_multiplier_16 dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Product(Product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one multiply; mode 1 pulses Start with A/B=7/9 mid-operation.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int mode);
    logic [31:0] prev, exp;
    int          busy_n, lat;
    bit          stable;
    prev   = Product;
    exp    = 32'(a) * 32'(b);
    busy_n = 0;
    lat    = -1;
    stable = 1'b1;
    @(negedge clk); A = a; B = b; Start = 1'b1;
    @(posedge clk); #1;
    if (Busy) busy_n++;
    @(negedge clk); Start = 1'b0; A = 16'($urandom); B = 16'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (mode == 1 && c == 5) begin A = 16'd7; B = 16'd9; Start = 1'b1; end
      @(posedge clk); #1;
      if (Busy) busy_n++;
      if (Done) begin lat = c; break; end
      if (Product !== prev) stable = 1'b0;
      @(negedge clk); Start = 1'b0;
    end
    Start = 1'b0;
    chk("latency", 32'(lat), 32'd16);
    chk("product", Product, exp);
    chk("product_hold", 32'(stable), 32'd1);
    @(posedge clk); #1;
    if (Busy) busy_n++;
    chk("busy_cycles", 32'(busy_n), 32'd17);
    chk("done_clear", 32'(Done), 32'd0);
  endtask

  task automatic no_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (Done || Busy) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_product", Product, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op(16'd234, 16'd523, 0);
    chk("p_234x523", Product, 32'd122382);
    run_op(16'hFFFF, 16'hFFFF, 0);
    chk("p_ffff_sq", Product, 32'hFFFE0001);

    run_op(16'd3245, 16'd16785, 0);
    chk("p_b2b_1", Product, 32'd54467325);
    run_op(16'd25000, 16'd40535, 0);
    chk("p_b2b_2", Product, 32'd1013375000);

    run_op(16'd0, 16'd40535, 0);
    chk("p_zero_a", Product, 32'd0);
    run_op(16'd40535, 16'd0, 0);
    chk("p_zero_b", Product, 32'd0);
    run_op(16'd1, 16'h8000, 0);
    chk("p_one_msb", Product, 32'h00008000);

    run_op(16'd100, 16'd200, 1);
    chk("p_ignored_start", Product, 32'd20000);
    no_done("no_second_done", 20);

    // abort mid-run with reset after the 8th iteration
    @(negedge clk); A = 16'd25001; B = 16'd40535; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_product", Product, 32'h0);
    chk("abort_done", 32'(Done), 32'd0);
    no_done("abort_no_done", 20);
    run_op(16'd25001, 16'd40535, 0);
    chk("p_after_abort", Product, 32'd1013415535);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'hFFFF : 16'($urandom);
      run_op(ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
